// File: rtl/miniRISC_ctrl_pkg.sv
// Shared definitions for the miniRISC control sequencer: states, opcode/funct
// values, control encodings and the control bundle reused by datapath benches.
package miniRISC_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT
    } state_e;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_ADDI  = 6'b000001;
    localparam logic [5:0] OPC_COMPI = 6'b000010;
    localparam logic [5:0] OPC_SHIFT = 6'b000011;
    localparam logic [5:0] OPC_LOAD  = 6'b000100;
    localparam logic [5:0] OPC_STORE = 6'b000101;
    localparam logic [5:0] OPC_BR    = 6'b000110;
    localparam logic [5:0] OPC_B     = 6'b000111;
    localparam logic [5:0] OPC_BRC0  = 6'b001000;
    localparam logic [5:0] OPC_BRC1  = 6'b001001;
    localparam logic [5:0] OPC_BRC2  = 6'b001010;
    localparam logic [5:0] OPC_BRC3  = 6'b001011;
    localparam logic [5:0] OPC_CALL  = 6'b001100;
    localparam logic [5:0] OPC_HALT  = 6'b111111;

    localparam logic [4:0] FN_ADD  = 5'b00000;
    localparam logic [4:0] FN_COMP = 5'b00001;
    localparam logic [4:0] FN_AND  = 5'b00010;
    localparam logic [4:0] FN_XOR  = 5'b00011;

    localparam logic [1:0] ALU_NONE = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_AND  = 2'b10;
    localparam logic [1:0] ALU_XOR  = 2'b11;

    localparam logic [1:0] REGDST_RD   = 2'b00;
    localparam logic [1:0] REGDST_RT   = 2'b01;
    localparam logic [1:0] REGDST_LINK = 2'b10;

    localparam logic [1:0] M2R_ALU = 2'b00;
    localparam logic [1:0] M2R_MEM = 2'b01;
    localparam logic [1:0] M2R_PC  = 2'b10;

    localparam logic [1:0] JMP_CALL = 2'b01;

    typedef struct packed {
        logic       RegWrite;
        logic       ImmSel;
        logic       ALUSrc;
        logic       CompEnbl;
        logic       ShiftAmntSel;
        logic       ShiftEnbl;
        logic       ShortBr;
        logic       LongBr;
        logic       MemRead;
        logic       MemWrite;
        logic       BranchReg;
        logic [1:0] ALUOp;
        logic [1:0] RegDst;
        logic [1:0] ShiftType;
        logic [1:0] BranchType;
        logic [1:0] JumpType;
        logic [1:0] MemToReg;
    } ctrl_t;

    // Write-back bundle of a load: memory data into the rt register.
    function automatic ctrl_t load_wb_ctrl();
        ctrl_t c;
        c          = '0;
        c.RegWrite = 1'b1;
        c.RegDst   = REGDST_RT;
        c.MemToReg = M2R_MEM;
        return c;
    endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational opcode/funct decoder producing the EXEC control bundle and
// instruction class flags; undefined encodings give an all-zero bundle.
module instr_decode
    import miniRISC_ctrl_pkg::*;
#(
    parameter int OPC_W = 6,
    parameter int FN_W  = 5
) (
    input  logic [OPC_W-1:0] opcode,
    input  logic [FN_W-1:0]  funct,
    output ctrl_t            ctrl,
    output logic             is_load,
    output logic             is_store,
    output logic             is_halt,
    output logic             is_illegal
);

    always_comb begin
        ctrl       = '0;
        is_load    = 1'b0;
        is_store   = 1'b0;
        is_halt    = 1'b0;
        is_illegal = 1'b0;
        case (opcode)
            OPC_RTYPE: begin
                ctrl.RegWrite = 1'b1;
                case (funct)
                    FN_ADD:  ctrl.ALUOp = ALU_ADD;
                    FN_COMP: begin
                        ctrl.ALUOp    = ALU_ADD;
                        ctrl.CompEnbl = 1'b1;
                    end
                    FN_AND:  ctrl.ALUOp = ALU_AND;
                    FN_XOR:  ctrl.ALUOp = ALU_XOR;
                    default: begin
                        ctrl       = '0;
                        is_illegal = 1'b1;
                    end
                endcase
            end
            OPC_ADDI, OPC_COMPI: begin
                ctrl.ALUSrc   = 1'b1;
                ctrl.ALUOp    = ALU_ADD;
                ctrl.RegWrite = 1'b1;
                ctrl.CompEnbl = (opcode == OPC_COMPI);
            end
            OPC_SHIFT: begin
                // funct[4:3] are reserved for shifts and must be zero.
                if (funct[4:3] == 2'b00) begin
                    ctrl.ShiftEnbl    = 1'b1;
                    ctrl.RegWrite     = 1'b1;
                    ctrl.ShiftAmntSel = funct[2];
                    ctrl.ShiftType    = funct[1:0];
                end else begin
                    is_illegal = 1'b1;
                end
            end
            OPC_LOAD: begin
                ctrl.ALUSrc  = 1'b1;
                ctrl.ImmSel  = 1'b1;
                ctrl.ALUOp   = ALU_ADD;
                ctrl.RegDst  = REGDST_RT;
                ctrl.MemRead = 1'b1;
                is_load      = 1'b1;
            end
            OPC_STORE: begin
                ctrl.ALUSrc   = 1'b1;
                ctrl.ImmSel   = 1'b1;
                ctrl.ALUOp    = ALU_ADD;
                ctrl.MemWrite = 1'b1;
                is_store      = 1'b1;
            end
            OPC_BR:   ctrl.BranchReg = 1'b1;
            OPC_B:    ctrl.LongBr    = 1'b1;
            OPC_BRC0, OPC_BRC1, OPC_BRC2, OPC_BRC3: begin
                ctrl.ShortBr    = 1'b1;
                ctrl.BranchType = opcode[1:0];
            end
            OPC_CALL: begin
                ctrl.LongBr   = 1'b1;
                ctrl.JumpType = JMP_CALL;
                ctrl.RegDst   = REGDST_LINK;
                ctrl.MemToReg = M2R_PC;
                ctrl.RegWrite = 1'b1;
            end
            OPC_HALT: is_halt = 1'b1;
            default:  is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_ctrl_seq.sv
// Multi-cycle control sequencer: fetch, decode, drive registered datapath
// controls for EXEC/MEM/WB, and pulse pc_en once per retired instruction.
module instr_ctrl_seq
    import miniRISC_ctrl_pkg::*;
#(
    parameter int OPC_W = 6,
    parameter int FN_W  = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        instr_req,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    output logic        pc_en,
    output logic        halted,
    output logic        illegal,
    output logic        RegWrite,
    output logic        ImmSel,
    output logic        ALUSrc,
    output logic        CompEnbl,
    output logic        ShiftAmntSel,
    output logic        ShiftEnbl,
    output logic        ShortBr,
    output logic        LongBr,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        BranchReg,
    output logic [1:0]  ALUOp,
    output logic [1:0]  RegDst,
    output logic [1:0]  ShiftType,
    output logic [1:0]  BranchType,
    output logic [1:0]  JumpType,
    output logic [1:0]  MemToReg
);

    state_e           state_q, state_d;
    logic [OPC_W-1:0] opc_q, opc_d;
    logic [FN_W-1:0]  fn_q, fn_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic             illegal_q, illegal_d;

    ctrl_t dec_ctrl;
    logic  dec_load, dec_store, dec_halt, dec_illegal;
    logic  instr_unused;

    // Register fields between opcode and funct are not used by the control path.
    assign instr_unused = ^instr[31-OPC_W:FN_W];

    instr_decode #(.OPC_W(OPC_W), .FN_W(FN_W)) u_decode (
        .opcode     (opc_q),
        .funct      (fn_q),
        .ctrl       (dec_ctrl),
        .is_load    (dec_load),
        .is_store   (dec_store),
        .is_halt    (dec_halt),
        .is_illegal (dec_illegal)
    );

    always_comb begin
        state_d   = state_q;
        opc_d     = opc_q;
        fn_d      = fn_q;
        illegal_d = illegal_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_FETCH;
            ST_FETCH: begin
                if (instr_valid) begin
                    opc_d   = instr[31 -: OPC_W];
                    fn_d    = instr[FN_W-1:0];
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (dec_halt) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_EXEC;
                    if (dec_illegal) illegal_d = 1'b1;
                end
            end
            ST_EXEC:  state_d = (dec_load || dec_store) ? ST_MEM : ST_FETCH;
            ST_MEM:   if (mem_ready) state_d = dec_load ? ST_WB : ST_FETCH;
            ST_WB:    state_d = ST_FETCH;
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_IDLE;
        endcase

        // Controls follow the state being entered: only EXEC, MEM and WB carry any.
        ctrl_d = '0;
        case (state_d)
            ST_EXEC: ctrl_d = dec_ctrl;
            ST_MEM:  ctrl_d = ctrl_q;
            ST_WB:   ctrl_d = load_wb_ctrl();
            default: ctrl_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            opc_q     <= '0;
            fn_q      <= '0;
            ctrl_q    <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            opc_q     <= opc_d;
            fn_q      <= fn_d;
            ctrl_q    <= ctrl_d;
            illegal_q <= illegal_d;
        end
    end

    // A store retires in the MEM cycle that sees mem_ready; loads retire in WB.
    always_comb begin
        pc_en = 1'b0;
        case (state_q)
            ST_EXEC: pc_en = !(dec_load || dec_store);
            ST_MEM:  pc_en = mem_ready && dec_store;
            ST_WB:   pc_en = 1'b1;
            default: pc_en = 1'b0;
        endcase
    end

    assign instr_req    = (state_q == ST_FETCH);
    assign halted       = (state_q == ST_HALT);
    assign illegal      = illegal_q;
    assign RegWrite     = ctrl_q.RegWrite;
    assign ImmSel       = ctrl_q.ImmSel;
    assign ALUSrc       = ctrl_q.ALUSrc;
    assign CompEnbl     = ctrl_q.CompEnbl;
    assign ShiftAmntSel = ctrl_q.ShiftAmntSel;
    assign ShiftEnbl    = ctrl_q.ShiftEnbl;
    assign ShortBr      = ctrl_q.ShortBr;
    assign LongBr       = ctrl_q.LongBr;
    assign MemRead      = ctrl_q.MemRead;
    assign MemWrite     = ctrl_q.MemWrite;
    assign BranchReg    = ctrl_q.BranchReg;
    assign ALUOp        = ctrl_q.ALUOp;
    assign RegDst       = ctrl_q.RegDst;
    assign ShiftType    = ctrl_q.ShiftType;
    assign BranchType   = ctrl_q.BranchType;
    assign JumpType     = ctrl_q.JumpType;
    assign MemToReg     = ctrl_q.MemToReg;

endmodule

// File: tb/tb_instr_ctrl_seq.sv
// Bench for instr_ctrl_seq: directed vector table, hand-written halt/reset
// sequences, and random instructions against a transaction-level model.
module tb_instr_ctrl_seq;
    import miniRISC_ctrl_pkg::*;

    localparam int K_ALU   = 0;
    localparam int K_LOAD  = 1;
    localparam int K_STORE = 2;
    localparam int K_HALT  = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        instr_valid = 1'b0;
    logic        mem_ready = 1'b0;
    logic [31:0] instr = '0;
    logic        instr_req, pc_en, halted, illegal;
    logic        RegWrite, ImmSel, ALUSrc, CompEnbl, ShiftAmntSel, ShiftEnbl;
    logic        ShortBr, LongBr, MemRead, MemWrite, BranchReg;
    logic [1:0]  ALUOp, RegDst, ShiftType, BranchType, JumpType, MemToReg;
    ctrl_t       got;

    int checks = 0;
    int errors = 0;
    bit ill_model = 1'b0;

    typedef struct {
        logic [31:0] ins;
        int          n_mem;
        int          kind;
        bit          ill;
        ctrl_t       exp;
    } vec_t;

    vec_t tbl[18];

    always #5 clk = ~clk;

    assign got = {RegWrite, ImmSel, ALUSrc, CompEnbl, ShiftAmntSel, ShiftEnbl,
                  ShortBr, LongBr, MemRead, MemWrite, BranchReg,
                  ALUOp, RegDst, ShiftType, BranchType, JumpType, MemToReg};

    instr_ctrl_seq #(.OPC_W(6), .FN_W(5)) dut (
        .clk(clk), .rst(rst), .start(start), .instr_req(instr_req),
        .instr_valid(instr_valid), .instr(instr), .mem_ready(mem_ready),
        .pc_en(pc_en), .halted(halted), .illegal(illegal),
        .RegWrite(RegWrite), .ImmSel(ImmSel), .ALUSrc(ALUSrc), .CompEnbl(CompEnbl),
        .ShiftAmntSel(ShiftAmntSel), .ShiftEnbl(ShiftEnbl), .ShortBr(ShortBr),
        .LongBr(LongBr), .MemRead(MemRead), .MemWrite(MemWrite), .BranchReg(BranchReg),
        .ALUOp(ALUOp), .RegDst(RegDst), .ShiftType(ShiftType), .BranchType(BranchType),
        .JumpType(JumpType), .MemToReg(MemToReg)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] fn);
        return {op, 21'h15A5A5, fn};
    endfunction

    function automatic vec_t mkv(input logic [31:0] ins, input int n, input int kind,
                                 input bit ill, input ctrl_t exp);
        vec_t v;
        v.ins = ins; v.n_mem = n; v.kind = kind; v.ill = ill; v.exp = exp;
        return v;
    endfunction

    // Transaction-level reference: instruction class, EXEC bundle, illegal flag.
    function automatic void model(input logic [31:0] ins, output int kind,
                                  output bit ill, output ctrl_t c);
        int op, fn;
        op = int'(ins[31:26]);
        fn = int'(ins[4:0]);
        c = '0; ill = 1'b0; kind = K_ALU;
        if (op == 0) begin
            if (fn < 4) begin
                c.RegWrite = 1'b1;
                c.CompEnbl = (fn == 1);
                c.ALUOp    = (fn <= 1) ? 2'd1 : 2'(fn);
            end else ill = 1'b1;
        end else if (op == 1 || op == 2) begin
            c.ALUSrc = 1'b1; c.ALUOp = 2'd1; c.RegWrite = 1'b1; c.CompEnbl = (op == 2);
        end else if (op == 3) begin
            if (fn < 8) begin
                c.ShiftEnbl = 1'b1; c.RegWrite = 1'b1;
                c.ShiftAmntSel = (fn >= 4); c.ShiftType = 2'(fn % 4);
            end else ill = 1'b1;
        end else if (op == 4 || op == 5) begin
            c.ALUSrc = 1'b1; c.ImmSel = 1'b1; c.ALUOp = 2'd1;
            if (op == 4) begin c.RegDst = 2'd1; c.MemRead = 1'b1; kind = K_LOAD; end
            else begin c.MemWrite = 1'b1; kind = K_STORE; end
        end else if (op == 6) c.BranchReg = 1'b1;
        else if (op == 7) c.LongBr = 1'b1;
        else if (op >= 8 && op <= 11) begin
            c.ShortBr = 1'b1; c.BranchType = 2'(op - 8);
        end else if (op == 12) begin
            c.LongBr = 1'b1; c.JumpType = 2'd1; c.RegDst = 2'd2; c.MemToReg = 2'd2; c.RegWrite = 1'b1;
        end else if (op == 63) kind = K_HALT;
        else ill = 1'b1;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; start = 1'b0; instr_valid = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        chk("reset_outs", 32'({got, pc_en, halted, illegal, instr_req}), 32'd0);
        rst = 1'b1;
        ill_model = 1'b0;
        @(negedge clk);
        chk("idle_no_req", 32'(instr_req), 32'd0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Runs one instruction from its FETCH; called at a negedge.
    task automatic run_instr(input logic [31:0] ins, input int n_mem, input int kind,
                             input ctrl_t exp, input bit ill, input string name);
        int w, pc_cnt, pc_at, fetch_at, exp_pc_at, exp_fetch;
        bit hold_ok, halted_seen, is_mem;
        ctrl_t exec_c, wb_c, wb_exp;
        wb_exp = '0; wb_exp.RegWrite = 1'b1; wb_exp.RegDst = 2'b01; wb_exp.MemToReg = 2'b01;
        is_mem = (kind == K_LOAD || kind == K_STORE);
        w = 0;
        while (!instr_req && w < 20) begin @(negedge clk); w++; end
        if (!instr_req) begin
            chk({name, "_fetch_timeout"}, 32'd0, 32'd1);
            return;
        end
        instr_valid = 1'b1; instr = ins;
        @(negedge clk);
        instr_valid = 1'b0; instr = $urandom;
        pc_cnt = 0; pc_at = -1; fetch_at = -1; hold_ok = 1'b1;
        exec_c = '0; wb_c = '0; halted_seen = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (instr_req) begin fetch_at = k; break; end
            if (k == 2) begin exec_c = got; halted_seen = halted; end
            if (is_mem && k >= 3 && k <= 2 + n_mem && got !== exp) hold_ok = 1'b0;
            if (kind == K_LOAD && k == 3 + n_mem) wb_c = got;
            if (kind == K_HALT && k >= 6) break;
            mem_ready = is_mem && (k == 2 || k == 2 + n_mem);
            instr_valid = 1'($urandom_range(0, 1));
            if (kind == K_HALT) start = 1'b1;
            #1;
            if (pc_en) begin pc_cnt++; pc_at = k; end
            @(negedge clk);
        end
        instr_valid = 1'b0; mem_ready = 1'b0; start = 1'b0;
        if (kind == K_HALT) begin
            chk({name, "_halted"}, 32'(halted_seen), 32'd1);
            chk({name, "_halt_ctrl"}, 32'(exec_c), 32'd0);
            chk({name, "_halt_pc_en"}, 32'(pc_cnt), 32'd0);
            chk({name, "_halt_stays"}, 32'(fetch_at), 32'hFFFF_FFFF);
        end else begin
            exp_pc_at = (kind == K_LOAD) ? 3 + n_mem : (kind == K_STORE) ? 2 + n_mem : 2;
            exp_fetch = (kind == K_LOAD) ? 4 + n_mem : (kind == K_STORE) ? 3 + n_mem : 3;
            chk({name, "_exec_ctrl"}, 32'(exec_c), 32'(exp));
            chk({name, "_pc_cnt"}, 32'(pc_cnt), 32'd1);
            chk({name, "_pc_at"}, 32'(pc_at), 32'(exp_pc_at));
            chk({name, "_latency"}, 32'(fetch_at), 32'(exp_fetch));
            if (is_mem) chk({name, "_mem_hold"}, 32'(hold_ok), 32'd1);
            if (kind == K_LOAD) chk({name, "_wb_ctrl"}, 32'(wb_c), 32'(wb_exp));
        end
        ill_model = ill_model | ill;
        chk({name, "_illegal"}, 32'(illegal), 32'(ill_model));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int kind, n, pc;
        bit ill;
        ctrl_t c;
        logic [31:0] ins;
        logic [5:0] op;
        logic [4:0] fn;

        tbl[0]  = mkv(mk(6'b000001, 5'd0), 0, K_ALU, 0, '{ALUSrc:1'b1, ALUOp:2'b01, RegWrite:1'b1, default:'0});
        tbl[1]  = mkv(mk(6'b000100, 5'd0), 3, K_LOAD, 0, '{ALUSrc:1'b1, ImmSel:1'b1, ALUOp:2'b01, RegDst:2'b01, MemRead:1'b1, default:'0});
        tbl[2]  = mkv(mk(6'b000000, 5'd1), 0, K_ALU, 0, '{ALUOp:2'b01, CompEnbl:1'b1, RegWrite:1'b1, default:'0});
        tbl[3]  = mkv(mk(6'b001010, 5'd0), 0, K_ALU, 0, '{ShortBr:1'b1, BranchType:2'b10, default:'0});
        tbl[4]  = mkv(mk(6'b010101, 5'd0), 0, K_ALU, 1, '0);
        tbl[5]  = mkv(mk(6'b000000, 5'd0), 0, K_ALU, 0, '{ALUOp:2'b01, RegWrite:1'b1, default:'0});
        tbl[6]  = mkv(mk(6'b000000, 5'd2), 0, K_ALU, 0, '{ALUOp:2'b10, RegWrite:1'b1, default:'0});
        tbl[7]  = mkv(mk(6'b000000, 5'd3), 0, K_ALU, 0, '{ALUOp:2'b11, RegWrite:1'b1, default:'0});
        tbl[8]  = mkv(mk(6'b000000, 5'd7), 0, K_ALU, 1, '0);
        tbl[9]  = mkv(mk(6'b000010, 5'd0), 0, K_ALU, 0, '{ALUSrc:1'b1, ALUOp:2'b01, RegWrite:1'b1, CompEnbl:1'b1, default:'0});
        tbl[10] = mkv(mk(6'b000011, 5'b00110), 0, K_ALU, 0, '{ShiftEnbl:1'b1, RegWrite:1'b1, ShiftAmntSel:1'b1, ShiftType:2'b10, default:'0});
        tbl[11] = mkv(mk(6'b000011, 5'b01001), 0, K_ALU, 1, '0);
        tbl[12] = mkv(mk(6'b000101, 5'd0), 2, K_STORE, 0, '{ALUSrc:1'b1, ImmSel:1'b1, ALUOp:2'b01, MemWrite:1'b1, default:'0});
        tbl[13] = mkv(mk(6'b000110, 5'd0), 0, K_ALU, 0, '{BranchReg:1'b1, default:'0});
        tbl[14] = mkv(mk(6'b000111, 5'd0), 0, K_ALU, 0, '{LongBr:1'b1, default:'0});
        tbl[15] = mkv(mk(6'b001100, 5'd0), 0, K_ALU, 0, '{LongBr:1'b1, JumpType:2'b01, RegDst:2'b10, MemToReg:2'b10, RegWrite:1'b1, default:'0});
        tbl[16] = mkv(mk(6'b000101, 5'd0), 1, K_STORE, 0, '{ALUSrc:1'b1, ImmSel:1'b1, ALUOp:2'b01, MemWrite:1'b1, default:'0});
        tbl[17] = mkv(mk(6'b001011, 5'd0), 0, K_ALU, 0, '{ShortBr:1'b1, BranchType:2'b11, default:'0});

        do_reset();
        for (int i = 0; i < 18; i++) begin
            run_instr(tbl[i].ins, tbl[i].n_mem, tbl[i].kind, tbl[i].exp, tbl[i].ill,
                      $sformatf("vec%0d", i));
            $display("vec %0d instr=%h done", i, tbl[i].ins);
        end

        // Halt: stays halted with start/instr_valid toggling, only reset exits.
        run_instr(mk(6'b111111, 5'd0), 0, K_HALT, '0, 0, "halt");
        $display("halt sequence done");
        do_reset();
        chk("illegal_cleared", 32'(illegal), 32'd0);

        // Store with mem_ready low; reset lands in the second MEM cycle.
        instr_valid = 1'b1; instr = mk(6'b000101, 5'd0);
        @(negedge clk);
        instr_valid = 1'b0; mem_ready = 1'b0; pc = 0;
        for (int k = 1; k <= 3; k++) begin
            if (pc_en) pc++;
            @(negedge clk);
        end
        chk("mem2_memwrite", 32'(MemWrite), 32'd1);
        if (pc_en) pc++;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_mem_reset_outs", 32'({got, pc_en, halted, illegal, instr_req}), 32'd0);
        chk("mid_mem_reset_pc", 32'(pc), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        $display("store reset sequence done");

        for (int t = 0; t < 60; t++) begin
            n = $urandom_range(0, 19);
            if (n <= 12) op = 6'(n);
            else if (n <= 18) op = 6'($urandom_range(13, 62));
            else op = 6'd63;
            fn = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            ins = {op, 21'($urandom), fn};
            model(ins, kind, ill, c);
            n = $urandom_range(1, 4);
            run_instr(ins, n, kind, c, ill, $sformatf("rand%0d", t));
            $display("rand %0d instr=%h kind=%0d n_mem=%0d", t, ins, kind, n);
            if (kind == K_HALT) do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
